button_conditioner: RTL and testbench

- Input-conditioning stage sitting directly upstream of the game core.
- Takes raw, bouncy, asynchronous push-button levels (Left, Right, clear) and synchronises and debounces them.
- Generates one-cycle press pulses and optional hold-to-repeat pulses on the fast board clock.
- Latches every event into a sticky flag. The flag is held until the slow game-tick logic acknowledges it, so no press is lost between game ticks.

---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects raw push-buttons,
// optionally generates hold-to-repeat pulses, and latches every event into a
// sticky flag that the slow game-tick logic clears with evt_ack.
// Optional feature macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN
//   defined   -> per-channel repeat FSM and counter are built
//   undefined -> btn_rpt is tied to 0 and events come from presses only
module button_conditioner #(
    parameter int NBTN       = 3,
    parameter int DB_CYCLES  = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 7500000
) (
    input  logic            CLK,
    input  logic            clear_n,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_rpt,
    output logic [NBTN-1:0] btn_evt,
    input  logic [NBTN-1:0] evt_ack,
    output logic [NBTN-1:0] evt_ovf
);

    localparam int DB_W = $clog2(DB_CYCLES) + 1;

    // Refuse to elaborate with a debounce window too short to filter anything
    // or with a repeat timing that would underflow the terminal-count compare.
    if (DB_CYCLES < 2 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
        $error("button_conditioner: DB_CYCLES must be >= 2, RPT_DELAY and RPT_PERIOD >= 1");
    end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_e;
`endif

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        logic            sync1_q, sync1_d;
        logic            sync2_q, sync2_d;
        logic            level_q, level_d;
        logic            level_dly_q, level_dly_d;
        logic            press_q, press_d;
        logic            evt_q, evt_d;
        logic            ovf_q, ovf_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            rpt;
        logic            ev;

        // Next-state for synchroniser, debounce counter, rise detect and event latch
        always_comb begin
            // NOTE: every variable gets a default before any branch, so no path can infer a latch.
            sync1_d     = btn_raw[i];
            sync2_d     = sync1_q;
            level_d     = level_q;
            db_cnt_d    = '0;
            level_dly_d = level_q;
            press_d     = level_q & ~level_dly_q;
            ev          = press_q | rpt;
            evt_d       = evt_q;
            ovf_d       = ovf_q;

            // The counter only runs while the synchronised input disagrees with
            // the accepted level; any agreement restarts the stability window.
            if (sync2_q != level_q) begin
                if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    level_d  = sync2_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            // A new event always wins over an acknowledge in the same cycle;
            // overrun is only flagged when the pending event was not being taken.
            if (ev) begin
                evt_d = 1'b1;
                if (evt_q && !evt_ack[i]) begin
                    ovf_d = 1'b1;
                end
            end else if (evt_ack[i]) begin
                evt_d = 1'b0;
                ovf_d = 1'b0;
            end
        end

        // Register the channel datapath; reset clears everything immediately
        always_ff @(posedge CLK or negedge clear_n) begin
            if (!clear_n) begin
                sync1_q     <= 1'b0;
                sync2_q     <= 1'b0;
                level_q     <= 1'b0;
                level_dly_q <= 1'b0;
                press_q     <= 1'b0;
                evt_q       <= 1'b0;
                ovf_q       <= 1'b0;
                db_cnt_q    <= '0;
            end else begin
                // NOTE: non-blocking assignments so every flop samples pre-edge values.
                sync1_q     <= sync1_d;
                sync2_q     <= sync2_d;
                level_q     <= level_d;
                level_dly_q <= level_dly_d;
                press_q     <= press_d;
                evt_q       <= evt_d;
                ovf_q       <= ovf_d;
                db_cnt_q    <= db_cnt_d;
            end
        end

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        rpt_state_e       state_q;
        logic [RPT_W-1:0] rpt_cnt_q;
        logic             rpt_q;

        // Repeat FSM: arms on the edge that raises btn_press, fires after the
        // initial delay and then periodically; release wins over a due pulse
        always_ff @(posedge CLK or negedge clear_n) begin
            if (!clear_n) begin
                state_q   <= RPT_IDLE;
                rpt_cnt_q <= '0;
                rpt_q     <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                case (state_q)
                    RPT_IDLE: begin
                        if (press_d) begin
                            state_q   <= RPT_HOLD;
                            rpt_cnt_q <= '0;
                        end
                    end
                    RPT_HOLD: begin
                        if (!level_q) begin
                            state_q   <= RPT_IDLE;
                            rpt_cnt_q <= '0;
                        end else if (rpt_cnt_q == RPT_W'(RPT_DELAY - 1)) begin
                            rpt_q     <= 1'b1;
                            state_q   <= RPT_REPEAT;
                            rpt_cnt_q <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!level_q) begin
                            state_q   <= RPT_IDLE;
                            rpt_cnt_q <= '0;
                        end else if (rpt_cnt_q == RPT_W'(RPT_PERIOD - 1)) begin
                            rpt_q     <= 1'b1;
                            rpt_cnt_q <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= RPT_IDLE;
                        rpt_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign rpt = rpt_q;
`else
        assign rpt = 1'b0;
`endif

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
        assign btn_rpt[i]   = rpt;
        assign btn_evt[i]   = evt_q;
        assign evt_ovf[i]   = ovf_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus for button_conditioner with a
// behavioural reference model compared against the DUT on every falling edge,
// plus hand-computed literal expectations at key points.
// Follows BUTTON_CONDITIONER_AUTO_REPEAT_EN to know whether repeats exist.
module tb_button_conditioner;

    localparam int NBTN = 3;
    localparam int DB   = 4;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    localparam int RD   = 10;
    localparam int RP   = 3;
`endif

    logic            CLK     = 1'b0;
    logic            clear_n = 1'b0;
    logic [NBTN-1:0] btn_raw = '0;
    logic [NBTN-1:0] evt_ack = '0;
    logic [NBTN-1:0] btn_level, btn_press, btn_rpt, btn_evt, evt_ovf;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .NBTN      (NBTN),
        .DB_CYCLES (DB),
        .RPT_DELAY (10),
        .RPT_PERIOD(3)
    ) dut (
        .CLK      (CLK),
        .clear_n  (clear_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_rpt  (btn_rpt),
        .btn_evt  (btn_evt),
        .evt_ack  (evt_ack),
        .evt_ovf  (evt_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Level accepted once the synchronised input has shown the opposite value
    // for DB consecutive edges; press is the rise of that level one cycle late;
    // repeats land at RD, RD+RP, RD+2RP... edges after the press while held.
    logic [NBTN-1:0] m_s1, m_s2, m_runv, m_lvl, m_lvlp, m_press, m_rpt, m_evt, m_ovf;
    int              m_runl [NBTN];
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
    logic [NBTN-1:0] m_act;
    int              m_age  [NBTN];
`endif

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_runv = '0; m_lvl = '0; m_lvlp = '0;
        m_press = '0; m_rpt = '0; m_evt = '0; m_ovf = '0;
        for (int i = 0; i < NBTN; i++) m_runl[i] = 0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        m_act = '0;
        for (int i = 0; i < NBTN; i++) m_age[i] = 0;
`endif
    endtask

    task automatic model_step();
        for (int i = 0; i < NBTN; i++) begin
            logic s, nl, np, nr;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            int an;
`endif
            s = m_s2[i];
            if (m_runl[i] > 0 && s == m_runv[i]) begin
                if (m_runl[i] < DB) m_runl[i]++;
            end else begin
                m_runv[i] = s;
                m_runl[i] = 1;
            end
            nl = (s != m_lvl[i] && m_runl[i] >= DB) ? s : m_lvl[i];
            np = m_lvl[i] & ~m_lvlp[i];
            nr = 1'b0;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
            an = m_age[i] + 1;
            if (m_act[i] && m_lvl[i] && (an == RD || (an > RD && (an - RD) % RP == 0))) nr = 1'b1;
            if (np) begin
                m_act[i] = 1'b1;
                m_age[i] = 0;
            end else if (m_act[i] && !m_lvl[i]) begin
                m_act[i] = 1'b0;
            end else begin
                m_age[i] = an;
            end
`endif
            if (m_press[i] | m_rpt[i]) begin
                if (m_evt[i] && !evt_ack[i]) m_ovf[i] = 1'b1;
                m_evt[i] = 1'b1;
            end else if (evt_ack[i]) begin
                m_evt[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end
            m_s2[i]    = m_s1[i];
            m_s1[i]    = btn_raw[i];
            m_lvlp[i]  = m_lvl[i];
            m_lvl[i]   = nl;
            m_press[i] = np;
            m_rpt[i]   = nr;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge clear_n);
            if (!clear_n) model_reset();
            else          model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge CLK);
            check("cmp_level", 32'(btn_level), 32'(m_lvl));
            check("cmp_press", 32'(btn_press), 32'(m_press));
            check("cmp_rpt",   32'(btn_rpt),   32'(m_rpt));
            check("cmp_evt",   32'(btn_evt),   32'(m_evt));
            check("cmp_ovf",   32'(evt_ovf),   32'(m_ovf));
        end
    end

    // Pulse counters (single writer)
    int press_cnt [NBTN];
    int rpt_cnt   [NBTN];
    initial begin
        for (int i = 0; i < NBTN; i++) begin
            press_cnt[i] = 0;
            rpt_cnt[i]   = 0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 0; i < NBTN; i++) begin
                if (btn_press[i]) press_cnt[i]++;
                if (btn_rpt[i])   rpt_cnt[i]++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic negs(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic ack_pulse(input logic [NBTN-1:0] m);
        @(negedge CLK);
        evt_ack = m;
        @(negedge CLK);
        evt_ack = '0;
    endtask

    // Raw press held for 'hold' cycles on channel ch, then released and settled
    task automatic short_press(input int ch, input int hold);
        @(negedge CLK);
        btn_raw[ch] = 1'b1;
        negs(hold);
        btn_raw[ch] = 1'b0;
        negs(12);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int p0, r0, p1;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_level", 32'(btn_level), 0);
        check("rst_press", 32'(btn_press), 0);
        check("rst_rpt",   32'(btn_rpt),   0);
        check("rst_evt",   32'(btn_evt),   0);
        check("rst_ovf",   32'(evt_ovf),   0);
        @(negedge CLK);
        clear_n = 1'b1;
        negs(3);

        // Clean press on channel 0, held 30 cycles
        p0 = press_cnt[0];
        r0 = rpt_cnt[0];
        btn_raw[0] = 1'b1;                   // sampled by edge 1
        negs(5);  check("clean_level_e5", 32'(btn_level[0]), 0);
        negs(1);  check("clean_level_e6", 32'(btn_level[0]), 1);
                  check("clean_press_e6", 32'(btn_press[0]), 0);
        negs(1);  check("clean_press_e7", 32'(btn_press[0]), 1);
                  check("clean_evt_e7",   32'(btn_evt[0]),   0);
        negs(1);  check("clean_press_e8", 32'(btn_press[0]), 0);
                  check("clean_evt_e8",   32'(btn_evt[0]),   1);
        negs(9);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("clean_rpt_e17", 32'(btn_rpt[0]), 1);
`else
        check("clean_rpt_e17", 32'(btn_rpt[0]), 0);
`endif
        negs(13);
        btn_raw[0] = 1'b0;                   // first low sample at edge 31
        negs(20);
        check("clean_press_count", press_cnt[0] - p0, 1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("clean_rpt_count", rpt_cnt[0] - r0, 7);
`else
        check("clean_rpt_count", rpt_cnt[0] - r0, 0);
`endif

        // Bounce on channel 1: 1,0,1,0 with 2-cycle widths, then held high
        p1 = press_cnt[1];
        @(negedge CLK); btn_raw[1] = 1'b1;
        negs(2);        btn_raw[1] = 1'b0;
        negs(2);        btn_raw[1] = 1'b1;
        negs(2);        btn_raw[1] = 1'b0;
        negs(2);
        check("bounce_level_during", 32'(btn_level[1]), 0);
        btn_raw[1] = 1'b1;                   // final stable edge
        negs(5);  check("bounce_level_e5", 32'(btn_level[1]), 0);
        negs(1);  check("bounce_level_e6", 32'(btn_level[1]), 1);
        negs(1);  check("bounce_press_e7", 32'(btn_press[1]), 1);
        negs(10);
        btn_raw[1] = 1'b0;
        negs(14);
        check("bounce_press_count", press_cnt[1] - p1, 1);

        // Overrun and acknowledge on channel 0
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("ovf_after_repeats", 32'(evt_ovf[0]), 1);
`else
        check("ovf_after_repeats", 32'(evt_ovf[0]), 0);
`endif
        ack_pulse(3'b111);
        check("ack_evt_clear", 32'(btn_evt), 0);
        check("ack_ovf_clear", 32'(evt_ovf), 0);
        short_press(0, 8);
        check("ovr_first_evt", 32'(btn_evt[0]), 1);
        check("ovr_first_ovf", 32'(evt_ovf[0]), 0);
        short_press(0, 8);
        check("ovr_second_ovf", 32'(evt_ovf[0]), 1);
        ack_pulse(3'b001);
        check("ovr_ack_evt", 32'(btn_evt[0]), 0);
        check("ovr_ack_ovf", 32'(evt_ovf[0]), 0);
        short_press(0, 8);
        check("ovr_rearm_evt", 32'(btn_evt[0]), 1);
        // Press whose event coincides with an acknowledge
        @(negedge CLK);
        btn_raw[0] = 1'b1;
        negs(7);
        check("coinc_press_e7", 32'(btn_press[0]), 1);
        evt_ack[0] = 1'b1;                   // sampled together with the event
        negs(1);
        evt_ack[0] = 1'b0;
        check("coinc_evt", 32'(btn_evt[0]), 1);
        check("coinc_ovf", 32'(evt_ovf[0]), 0);
        negs(1);
        btn_raw[0] = 1'b0;
        negs(14);

        // Simultaneous Left and Right
        ack_pulse(3'b111);
        @(negedge CLK);
        btn_raw = 3'b011;
        negs(6);  check("simul_level", 32'(btn_level), 32'h3);
        negs(1);  check("simul_press", 32'(btn_press), 32'h3);
        negs(1);  check("simul_evt",   32'(btn_evt),   32'h3);
        btn_raw = 3'b000;
        negs(14);

        // Reset during REPEAT with the button still held
        @(negedge CLK);
        btn_raw[0] = 1'b1;
        negs(19);                            // past the first repeat at edge 17
        #2;
        clear_n = 1'b0;
        #1;
        check("rst_mid_level", 32'(btn_level), 0);
        check("rst_mid_press", 32'(btn_press), 0);
        check("rst_mid_rpt",   32'(btn_rpt),   0);
        check("rst_mid_evt",   32'(btn_evt),   0);
        check("rst_mid_ovf",   32'(evt_ovf),   0);
        negs(2);
        #2;
        clear_n = 1'b1;                      // next rising edge is edge 1
        negs(5);  check("rst_rel_level_e5", 32'(btn_level[0]), 0);
        negs(1);  check("rst_rel_level_e6", 32'(btn_level[0]), 1);
        negs(1);  check("rst_rel_press_e7", 32'(btn_press[0]), 1);
        btn_raw[0] = 1'b0;
        negs(14);

        // 40-cycle hold: the repeat due at edge 47 meets the release and is dropped
        p0 = press_cnt[0];
        r0 = rpt_cnt[0];
        @(negedge CLK);
        btn_raw[0] = 1'b1;
        negs(40);
        btn_raw[0] = 1'b0;
        negs(20);
        check("hold40_press_count", press_cnt[0] - p0, 1);
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
        check("hold40_rpt_count", rpt_cnt[0] - r0, 10);
`else
        check("hold40_rpt_count", rpt_cnt[0] - r0, 0);
`endif
        check("ch2_untouched", press_cnt[2], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
